// File: rtl/gbf_loader.sv
`default_nettype none
// ============================================================================
// Module      : gbf_loader
// Description : Streams words into the two halves of a double-buffered global
//               buffer. Fills strictly alternate half 1 / half 2, each fill is
//               load_len words, and a half is only refilled after its consumer
//               has released it through bufX_need_data.
// Revision    : 1.0 - initial release
// ============================================================================
module gbf_loader #(
    parameter int GBF_DATA_BITWIDTH = 512,
    parameter int GBF_ADDR_BITWIDTH = 5,
    parameter int GBF_DEPTH         = 32,
    parameter int TILE_BITWIDTH     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [TILE_BITWIDTH-1:0]     tile_count,
    input  logic [GBF_ADDR_BITWIDTH:0]   load_len,
    input  logic                         buf1_need_data,
    input  logic                         buf2_need_data,
    input  logic                         s_valid,
    input  logic [GBF_DATA_BITWIDTH-1:0] s_data,
    output logic                         s_ready,
    output logic                         en1a,
    output logic                         we1a,
    output logic                         en2a,
    output logic                         we2a,
    output logic [GBF_ADDR_BITWIDTH-1:0] addr1a,
    output logic [GBF_ADDR_BITWIDTH-1:0] addr2a,
    output logic [GBF_DATA_BITWIDTH-1:0] w_data1a,
    output logic [GBF_DATA_BITWIDTH-1:0] w_data2a,
    output logic                         buf1_ready,
    output logic                         buf2_ready,
    output logic                         data_avail,
    output logic                         busy,
    output logic                         done
);

    // Length counters carry one extra bit so a full-depth fill is representable.
    localparam int c_LW = GBF_ADDR_BITWIDTH + 1;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_FILL1 = 3'd1;
    localparam logic [2:0] c_S_FILL2 = 3'd2;
    localparam logic [2:0] c_S_WAIT  = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    localparam logic [c_LW-1:0]          c_DEPTH     = c_LW'(GBF_DEPTH);
    localparam logic [c_LW-1:0]          c_LEN_ONE   = c_LW'(1);
    localparam logic [c_LW-1:0]          c_LEN_ZERO  = '0;
    localparam logic [TILE_BITWIDTH-1:0] c_TILE_ONE  = TILE_BITWIDTH'(1);
    localparam logic [TILE_BITWIDTH-1:0] c_TILE_ZERO = '0;

    logic [2:0]                   r_state;
    logic [2:0]                   w_state_nxt;
    logic [c_LW-1:0]              r_cnt;
    logic [c_LW-1:0]              r_len;
    logic [TILE_BITWIDTH-1:0]     r_tiles_left;
    logic                         r_next_buf2;   // 0: next fill targets half 1, 1: half 2
    logic                         r_buf1_ready;
    logic                         r_buf2_ready;
    logic                         r_en1a;
    logic                         r_en2a;
    logic [GBF_ADDR_BITWIDTH-1:0] r_addr1a;
    logic [GBF_ADDR_BITWIDTH-1:0] r_addr2a;
    logic [GBF_DATA_BITWIDTH-1:0] r_wdata1a;
    logic [GBF_DATA_BITWIDTH-1:0] r_wdata2a;

    logic                         w_in_fill1;
    logic                         w_in_fill2;
    logic                         w_in_fill;
    logic                         w_hs;
    logic                         w_last;
    logic                         w_start_ok;
    logic [c_LW-1:0]              w_len_clamped;

    assign w_in_fill1    = (r_state == c_S_FILL1);
    assign w_in_fill2    = (r_state == c_S_FILL2);
    assign w_in_fill     = w_in_fill1 | w_in_fill2;
    assign w_hs          = s_valid & w_in_fill;
    assign w_last        = w_hs & (r_cnt == (r_len - c_LEN_ONE));
    assign w_start_ok    = start & ((r_state == c_S_IDLE) | (r_state == c_S_DONE));
    assign w_len_clamped = ((load_len == c_LEN_ZERO) || (load_len > c_DEPTH)) ? c_DEPTH : load_len;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; WAIT releases a fill only into the half named by next_buf.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE, c_S_DONE: begin
                if (start) begin
                    w_state_nxt = (tile_count == c_TILE_ZERO) ? c_S_DONE : c_S_FILL1;
                end
            end
            c_S_FILL1, c_S_FILL2: begin
                if (w_last) begin
                    w_state_nxt = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                if (r_tiles_left == c_TILE_ZERO) begin
                    w_state_nxt = c_S_DONE;
                end else if (!r_next_buf2 && !r_buf1_ready) begin
                    w_state_nxt = c_S_FILL1;
                end else if (r_next_buf2 && !r_buf2_ready) begin
                    w_state_nxt = c_S_FILL2;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // Job bookkeeping: latched length, remaining fills and the alternating target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len        <= c_LEN_ZERO;
            r_tiles_left <= c_TILE_ZERO;
            r_next_buf2  <= 1'b0;
        end else if (w_start_ok) begin
            r_len        <= w_len_clamped;
            r_tiles_left <= tile_count;
            r_next_buf2  <= 1'b0;
        end else if (w_last) begin
            r_tiles_left <= r_tiles_left - c_TILE_ONE;
            r_next_buf2  <= ~r_next_buf2;
        end
    end

    // Word counter: zero outside a fill and after the final word, advances per handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= c_LEN_ZERO;
        end else if (w_last || !w_in_fill) begin
            r_cnt <= c_LEN_ZERO;
        end else if (w_hs) begin
            r_cnt <= r_cnt + c_LEN_ONE;
        end
    end

    // Port-a write stage: one strobe the cycle after each handshake, address/data hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en1a    <= 1'b0;
            r_en2a    <= 1'b0;
            r_addr1a  <= '0;
            r_addr2a  <= '0;
            r_wdata1a <= '0;
            r_wdata2a <= '0;
        end else begin
            r_en1a <= w_hs & w_in_fill1;
            r_en2a <= w_hs & w_in_fill2;
            if (w_hs && w_in_fill1) begin
                r_addr1a  <= r_cnt[GBF_ADDR_BITWIDTH-1:0];
                r_wdata1a <= s_data;
            end
            if (w_hs && w_in_fill2) begin
                r_addr2a  <= r_cnt[GBF_ADDR_BITWIDTH-1:0];
                r_wdata2a <= s_data;
            end
        end
    end

    // Ready flags: set with the final write of a fill (set beats a same-cycle release).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf1_ready <= 1'b0;
            r_buf2_ready <= 1'b0;
        end else begin
            if (w_last && w_in_fill1) begin
                r_buf1_ready <= 1'b1;
            end else if (buf1_need_data) begin
                r_buf1_ready <= 1'b0;
            end
            if (w_last && w_in_fill2) begin
                r_buf2_ready <= 1'b1;
            end else if (buf2_need_data) begin
                r_buf2_ready <= 1'b0;
            end
        end
    end

    assign s_ready    = w_in_fill;
    assign en1a       = r_en1a;
    assign we1a       = r_en1a;
    assign en2a       = r_en2a;
    assign we2a       = r_en2a;
    assign addr1a     = r_addr1a;
    assign addr2a     = r_addr2a;
    assign w_data1a   = r_wdata1a;
    assign w_data2a   = r_wdata2a;
    assign buf1_ready = r_buf1_ready;
    assign buf2_ready = r_buf2_ready;
    assign data_avail = r_buf1_ready | r_buf2_ready;
    assign busy       = w_in_fill | (r_state == c_S_WAIT);
    assign done       = (r_state == c_S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_gbf_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_gbf_loader
// Description : Directed-plus-random bench for gbf_loader. Each job's expected
//               write list (half, address, word) is derived from the job
//               parameters and the stream words actually accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gbf_loader;

    localparam int DW    = 512;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int TW    = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [TW-1:0] tile_count;
    logic [AW:0]   load_len;
    logic          buf1_need_data;
    logic          buf2_need_data;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          en1a, we1a, en2a, we2a;
    logic [AW-1:0] addr1a, addr2a;
    logic [DW-1:0] w_data1a, w_data2a;
    logic          buf1_ready, buf2_ready, data_avail, busy, done;

    gbf_loader #(
        .GBF_DATA_BITWIDTH (DW),
        .GBF_ADDR_BITWIDTH (AW),
        .GBF_DEPTH         (DEPTH),
        .TILE_BITWIDTH     (TW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .tile_count     (tile_count),
        .load_len       (load_len),
        .buf1_need_data (buf1_need_data),
        .buf2_need_data (buf2_need_data),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .en1a           (en1a),
        .we1a           (we1a),
        .en2a           (en2a),
        .we2a           (we2a),
        .addr1a         (addr1a),
        .addr2a         (addr2a),
        .w_data1a       (w_data1a),
        .w_data2a       (w_data2a),
        .buf1_ready     (buf1_ready),
        .buf2_ready     (buf2_ready),
        .data_avail     (data_avail),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            nwr   = 0;
    int            last_wr_cyc = 0;
    bit            sready_seen = 0;
    bit            hs_pending  = 0;
    bit            auto_need   = 0;
    int            vmode       = 0;   // 0: always valid, 1: toggling, 2: random
    int            wi          = 0;
    int            cur_len     = 0;
    logic [DW-1:0] words[$];
    int            exp_buf[$];
    int            exp_addr[$];
    logic [DW-1:0] exp_data[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Compare one observed strobe against the head of the expected write list.
    task automatic see_write(input int b, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic we, input logic rdy);
        int eb, ea;
        logic [DW-1:0] ed;
        nwr++;
        last_wr_cyc = cyc;
        chk("write_enable", we, 1'b1);
        if (exp_buf.size() == 0) begin
            chk("spurious_strobe", we, 1'b0);
        end else begin
            eb = exp_buf.pop_front();
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            chk("write_half", b, eb);
            chk("write_addr", a, ea);
            chk("write_data", d, ed);
            if (ea == cur_len - 1) chk("ready_at_last_write", rdy, 1'b1);
            else                   chk("ready_before_last_write", rdy, 1'b0);
        end
    endtask

    // One clock: sample outputs after the rising edge, drive the stream on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (en1a) see_write(1, addr1a, w_data1a, we1a, buf1_ready);
        if (en2a) see_write(2, addr2a, w_data2a, we2a, buf2_ready);
        if (s_ready) sready_seen = 1;
        chk("data_avail", data_avail, buf1_ready | buf2_ready);
        @(negedge clk);
        if (hs_pending) wi++;
        case (vmode)
            0:       s_valid = 1'b1;
            1:       s_valid = ~s_valid;
            default: s_valid = (($urandom % 3) != 0);
        endcase
        s_data     = (wi < words.size()) ? words[wi] : rand_word();
        hs_pending = s_valid && s_ready;
        if (auto_need) begin
            buf1_need_data = buf1_ready && (($urandom % 3) == 0);
            buf2_need_data = buf2_ready && (($urandom % 3) == 0);
        end
    endtask

    // Build the reference write list for a job and issue the start pulse.
    task automatic begin_job(input int tiles, input int len, input int mode);
        cur_len = (len == 0 || len > DEPTH) ? DEPTH : len;
        words.delete();
        for (int i = 0; i < tiles * cur_len; i++) words.push_back(rand_word());
        for (int k = 0; k < tiles; k++) begin
            for (int a = 0; a < cur_len; a++) begin
                exp_buf.push_back((k % 2 == 0) ? 1 : 2);
                exp_addr.push_back(a);
                exp_data.push_back(words[k * cur_len + a]);
            end
        end
        wi         = 0;
        hs_pending = 0;
        vmode      = mode;
        s_valid    = 1'b0;
        tile_count = TW'(tiles);
        load_len   = (AW + 1)'(len);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_all_writes_seen"}, exp_buf.size(), 0);
        chk({tag, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic wait_ready2(input int budget, input string tag);
        int n = 0;
        while (buf2_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_buf2_ready"}, buf2_ready, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b0;
        start          = 1'b0;
        s_valid        = 1'b0;
        buf1_need_data = 1'b0;
        buf2_need_data = 1'b0;
        auto_need      = 0;
        hs_pending     = 0;
        words.delete();
        exp_buf.delete();
        exp_addr.delete();
        exp_data.delete();
        @(negedge clk);
        reset = 1'b1;
        nwr   = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        int tiles;
        reset          = 1'b1;
        start          = 1'b0;
        tile_count     = '0;
        load_len       = '0;
        buf1_need_data = 1'b0;
        buf2_need_data = 1'b0;
        s_valid        = 1'b0;
        s_data         = '0;

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_en1a", en1a, 1'b0);
        chk("rst_en2a", en2a, 1'b0);
        chk("rst_buf_ready", {buf1_ready, buf2_ready}, 2'b00);
        chk("rst_busy_done", {busy, done, data_avail}, 3'b000);
        chk("rst_addr", {addr1a, addr2a}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Basic job: two fills of four words, continuous stream
        do_reset();
        begin_job(2, 4, 0);
        wait_done(40, "basic");
        chk("basic_write_count", nwr, 8);
        chk("basic_done_after_last_write", cyc, last_wr_cyc + 1);
        chk("basic_both_ready", {buf1_ready, buf2_ready}, 2'b11);

        // Back-pressure: third fill waits for half 1 to be released
        do_reset();
        begin_job(3, 4, 0);
        wait_ready2(40, "bp");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_s_ready", s_ready, 1'b0);
            chk("bp_hold_busy", busy, 1'b1);
            chk("bp_hold_buf1_ready", buf1_ready, 1'b1);
        end
        buf1_need_data = 1'b1;
        tick();
        buf1_need_data = 1'b0;
        chk("bp_buf1_cleared", buf1_ready, 1'b0);
        wait_done(40, "bp");
        chk("bp_write_count", nwr, 12);

        // Stream stalls: valid toggling
        do_reset();
        begin_job(1, 4, 1);
        wait_done(40, "stall");
        chk("stall_write_count", nwr, 4);

        // Clamp: load_len = 0 means full depth
        do_reset();
        begin_job(1, 0, 0);
        wait_done(60, "clamp0");
        chk("clamp0_write_count", nwr, 32);

        // Clamp: oversize load_len, random stream
        do_reset();
        len = $urandom_range(33, 63);
        begin_job(2, len, 2);
        wait_done(400, "clampbig");
        chk("clampbig_write_count", nwr, 64);

        // Random job with a randomly-releasing consumer
        do_reset();
        tiles = $urandom_range(3, 6);
        len   = $urandom_range(1, 8);
        auto_need = 1;
        begin_job(tiles, len, 2);
        wait_done(tiles * len * 12 + 200, "random");
        chk("random_write_count", nwr, tiles * len);
        auto_need      = 0;
        buf1_need_data = 1'b0;
        buf2_need_data = 1'b0;

        // tile_count = 0: done one cycle after start, no writes
        do_reset();
        sready_seen = 0;
        begin_job(0, 4, 0);
        chk("zero_done_next_cycle", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        repeat (5) tick();
        chk("zero_write_count", nwr, 0);
        chk("zero_s_ready_never", sready_seen, 1'b0);
        chk("zero_done_held", done, 1'b1);

        // Out-of-order release requests
        do_reset();
        begin_job(3, 4, 0);
        buf2_need_data = 1'b1;
        tick();
        tick();
        buf2_need_data = 1'b0;
        chk("ooo_need_ignored_when_empty", buf2_ready, 1'b0);
        wait_ready2(40, "ooo");
        buf2_need_data = 1'b1;
        tick();
        buf2_need_data = 1'b0;
        chk("ooo_buf2_cleared", buf2_ready, 1'b0);
        chk("ooo_buf1_still_ready", buf1_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ooo_wait_for_buf1", s_ready, 1'b0);
        end
        buf1_need_data = 1'b1;
        tick();
        buf1_need_data = 1'b0;
        wait_done(40, "ooo");
        chk("ooo_write_count", nwr, 12);

        // Asynchronous reset in the middle of a fill
        do_reset();
        begin_job(1, 4, 0);
        n = 0;
        while (nwr < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("arst_two_writes_before", nwr, 2);
        #2 reset = 1'b0;
        #1;
        chk("arst_s_ready", s_ready, 1'b0);
        chk("arst_strobes", {en1a, we1a, en2a, we2a}, 4'b0000);
        chk("arst_addr1a", addr1a, '0);
        chk("arst_wdata1a", w_data1a, '0);
        chk("arst_flags", {buf1_ready, buf2_ready, data_avail, busy, done}, 5'b00000);
        words.delete();
        exp_buf.delete();
        exp_addr.delete();
        exp_data.delete();
        hs_pending = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) tick();
        chk("arst_no_writes_after_release", nwr, 2);
        begin_job(1, 4, 0);
        wait_done(40, "arst_restart");
        chk("arst_restart_write_count", nwr, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gbf_loader.md
GBF_LOADER -- requirements
Module: gbf_loader

Interface
REQ-001 SHALL have parameter GBF_DATA_BITWIDTH, default 512: width of one global-buffer word.
REQ-002 SHALL have parameter GBF_ADDR_BITWIDTH, default 5: global-buffer address width.
REQ-003 SHALL have parameter GBF_DEPTH, default 32: words per buffer half.
REQ-004 SHALL have parameter TILE_BITWIDTH, default 16: width of the tile count.
REQ-005 SHALL have ports, in this order:
- clk  input  1  the single clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle job start pulse.
- tile_count  input  TILE_BITWIDTH  number of buffer fills in the job.
- load_len  input  GBF_ADDR_BITWIDTH+1  words per fill.
- buf1_need_data, buf2_need_data  input  1 each  refill requests from the global-buffer controller.
- s_valid  input  1  stream data valid.
- s_data  input  GBF_DATA_BITWIDTH  stream word.
- s_ready  output  1  loader accepts a stream word.
- en1a, we1a, en2a, we2a  output  1 each  port-a write strobes, buffer halves 1 and 2.
- addr1a, addr2a  output  GBF_ADDR_BITWIDTH  port-a write addresses.
- w_data1a, w_data2a  output  GBF_DATA_BITWIDTH  port-a write data.
- buf1_ready, buf2_ready  output  1 each  buffer half holds a complete fill.
- data_avail  output  1  at least one buffer half holds a complete fill.
- busy  output  1  a job is in progress.
- done  output  1  all fills of the job have been written.

Function
REQ-006 SHALL use FSM states IDLE, FILL1, FILL2, WAIT and DONE.
REQ-007 start in IDLE or DONE SHALL latch tile_count and load_len, clear done, and select buffer 1 as the next buffer (next_buf=1).
- tile_count=0: the FSM SHALL go directly to DONE.
- Otherwise: the FSM SHALL go to FILL1.
REQ-008 start SHALL be ignored in FILL1, FILL2 and WAIT.
REQ-009 A latched load_len of 0 or greater than GBF_DEPTH SHALL be replaced by GBF_DEPTH.
REQ-010 s_ready SHALL equal 1 exactly while the state is FILL1 or FILL2 (decoded from the state register).
REQ-011 Each s_valid&&s_ready handshake SHALL, on the following cycle, produce one write on the active half:
- enXa=1 and weXa=1;
- addrXa = word counter value at the handshake;
- w_dataXa = s_data.
REQ-012 When no write is in progress, enXa and weXa SHALL be 0, and addrXa and w_dataXa SHALL hold their last values.
REQ-013 The word counter SHALL start at 0 on entering a FILL state and increment once per handshake.
REQ-014 On the handshake with counter = load_len-1:
- the FSM SHALL leave the FILL state;
- tiles_left SHALL decrement;
- next_buf SHALL toggle;
- bufX_ready SHALL set on the cycle after that handshake, i.e. the same cycle as the last write strobe.
REQ-015 From WAIT, the FSM SHALL go to FILL<next_buf> when tiles_left>0 and buf<next_buf>_ready=0.
REQ-016 From WAIT, the FSM SHALL go to DONE when tiles_left=0.
REQ-017 Fill order SHALL strictly alternate 1,2,1,2,... regardless of the order of need_data requests.
REQ-018 After a FILL state completes, the FSM SHALL go to WAIT.
REQ-019 bufX_need_data=1 while bufX_ready=1 SHALL clear bufX_ready on the next edge.
REQ-020 bufX_need_data SHALL be ignored while bufX_ready=0.
REQ-021 need_data for one half SHALL be honoured while the other half is filling.
REQ-022 If need_data and the ready-set for the same half coincide in one cycle, the set SHALL win.
REQ-023 data_avail SHALL equal buf1_ready | buf2_ready.
REQ-024 busy SHALL be 1 in FILL1, FILL2 and WAIT.
REQ-025 done SHALL be 1 in DONE and held until the next start.
REQ-026 A ready flag SHALL never be cleared by the loader itself except by need_data or reset.
REQ-027 s_valid SHALL be ignored outside the FILL states.
REQ-028 A stall (s_valid=0) SHALL hold the counter and produce no write.

Reset
REQ-029 Assertion of reset (low) SHALL immediately, without a clock edge, force:
- state=IDLE, counter=0, tiles_left=0, next_buf=1;
- s_ready, all enXa/weXa, buf1_ready, buf2_ready, data_avail, busy and done = 0;
- addrXa and w_dataXa = 0.
REQ-030 Reset mid-fill SHALL abandon the partial fill; no write strobe SHALL follow the reset release until a new start.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- Basic job: tile_count=2, load_len=4, s_valid constant 1.
  - Writes SHALL go to addr1a 0..3, then addr2a 0..3.
  - buf1_ready SHALL rise on the cycle of the addr1a=3 strobe.
  - done=1 SHALL follow the last write; busy=0.
- Back-pressure: tile_count=3, load_len=4, with buf1_need_data first asserted 10 cycles after buf2_ready.
  - The FSM SHALL hold in WAIT with s_ready=0 until buf1_ready clears.
  - The third fill SHALL then write addr1a 0..3.
- Stream stalls: s_valid toggling 1,0,1,0 during load_len=4.
  - Exactly 4 strobes SHALL occur, at addresses 0,1,2,3, with no duplicate address.
- Clamp and boundaries:
  - load_len=0, tile_count=1: SHALL produce 32 writes, addr 0..31.
  - tile_count=0: SHALL produce done one cycle after start, with zero writes and s_ready never 1.
- Out-of-order requests: buf2_need_data asserted before buf1_need_data with tiles remaining.
  - The next fill SHALL still target buffer 1 (per next_buf).
  - buf2_need_data with buf2_ready=0 SHALL have no effect.
- Async reset mid-fill: reset low after 2 of 4 words.
  - All outputs SHALL be 0 immediately.
  - After release and a new start, writes SHALL begin at addr1a=0.
